// File: rtl/sdram_mem_responder.sv
// Memory-side responder for the 64-bit burst SDRAM interface.
// It accepts 4-beat line writes and line reads, and returns each read as a
// 4-beat burst after a fixed latency, in request order.
//
// Write-burst FSM
//   state    | meaning
//   WR_IDLE  | no burst open; an accepted write stores word 0
//   WR_B1    | word 0 stored; expecting word 1 on the same line
//   WR_B2    | expecting word 2 on the same line
//   WR_B3    | expecting word 3, then back to WR_IDLE
//
// Return FSM
//   state    | meaning
//   RET_IDLE | waiting for the head read's latency to expire
//   RET_BEAT | driving beats 0..3 of the head read
module sdram_mem_responder #(
   parameter int LINE_BITS    = 6,
   parameter int READ_LATENCY = 8,
   parameter int QUEUE_DEPTH  = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] addr,
   input  logic        read,
   input  logic        write,
   input  logic [63:0] wdata,
   output logic        ready,
   output logic [63:0] rdata,
   output logic [31:0] raddr,
   output logic        rvalid,
   output logic        err
);

   localparam int LINES = 1 << LINE_BITS;
   localparam int PW    = $clog2(QUEUE_DEPTH);
   localparam int CD_W  = $clog2(READ_LATENCY);
   localparam logic [CD_W-1:0] CD_LOAD  = CD_W'(READ_LATENCY - 1);
   localparam logic [CD_W-1:0] CD_ONE   = CD_W'(1);
   localparam logic [PW:0]     CNT_ONE  = (PW+1)'(1);
   localparam logic [PW:0]     CNT_FULL = (PW+1)'(QUEUE_DEPTH);

   typedef enum logic [1:0] {WR_IDLE, WR_B1, WR_B2, WR_B3} wr_state_t;
   typedef enum logic {RET_IDLE, RET_BEAT} ret_state_t;

   wr_state_t  wr_state, wr_state_n;
   ret_state_t ret_state, ret_state_n;

   logic [26:0]     wr_line;
   logic [1:0]      beat, beat_n;
   logic [PW-1:0]   rd_ptr, wr_ptr, nxt_ptr;
   logic [PW:0]     count, count_n;
   logic [26:0]     q_line [QUEUE_DEPTH];
   logic [CD_W-1:0] q_cd   [QUEUE_DEPTH];
   logic [63:0]     mem    [LINES*4];

   logic        ready_q, err_q;
   logic        mem_we, viol, push, pop, head_due, next_due;
   logic [1:0]  mem_word;
   logic [LINE_BITS+1:0] wr_idx;
   logic        unused_addr;

   assign unused_addr = ^addr[4:0];
   assign wr_idx      = {addr[5+LINE_BITS-1:5], mem_word};
   assign nxt_ptr     = rd_ptr + 1'b1;

   // Write-burst decode: word strobes, burst violations and read acceptance.
   always_comb begin
      wr_state_n = wr_state;
      mem_we     = 1'b0;
      mem_word   = 2'd0;
      viol       = 1'b0;
      push       = 1'b0;
      if (wr_state == WR_IDLE) begin
         if (ready_q && write && !read) begin
            mem_we     = 1'b1;
            wr_state_n = WR_B1;
         end else if (ready_q && read && !write) begin
            push = 1'b1;
         end
      end else begin
         if (write && !read && addr[31:5] == wr_line) begin
            mem_we   = 1'b1;
            mem_word = wr_state;
            case (wr_state)
               WR_B1:   wr_state_n = WR_B2;
               WR_B2:   wr_state_n = WR_B3;
               default: wr_state_n = WR_IDLE;
            endcase
         end else begin
            // A broken burst is abandoned; any read in that cycle is dropped.
            viol       = 1'b1;
            wr_state_n = WR_IDLE;
         end
      end
   end

   // Return sequencing, queue occupancy and next-cycle ready.
   always_comb begin
      // "Due" means the countdown reaches 0 at this edge, so beat 0 lands
      // exactly READ_LATENCY cycles after acceptance.
      head_due    = (count != '0) && (q_cd[rd_ptr] <= CD_ONE);
      next_due    = (count > CNT_ONE) && (q_cd[nxt_ptr] <= CD_ONE);
      pop         = (ret_state == RET_BEAT) && (beat == 2'd3);
      ret_state_n = ret_state;
      beat_n      = 2'd0;
      if (ret_state == RET_IDLE) begin
         if (head_due) ret_state_n = RET_BEAT;
      end else begin
         beat_n = beat + 2'd1;
         if (pop && !next_due) ret_state_n = RET_IDLE;
      end
      count_n = count;
      if (push && !pop)      count_n = count + CNT_ONE;
      else if (!push && pop) count_n = count - CNT_ONE;
   end

   // Control state, queue pointers, sticky error and registered ready.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_state  <= WR_IDLE;
         wr_line   <= '0;
         ret_state <= RET_IDLE;
         beat      <= 2'd0;
         rd_ptr    <= '0;
         wr_ptr    <= '0;
         count     <= '0;
         err_q     <= 1'b0;
         ready_q   <= 1'b0;
      end else begin
         wr_state  <= wr_state_n;
         ret_state <= ret_state_n;
         beat      <= beat_n;
         count     <= count_n;
         err_q     <= err_q | viol | (read & write);
         ready_q   <= (count_n < CNT_FULL) || (wr_state_n != WR_IDLE);
         if (wr_state == WR_IDLE && mem_we) wr_line <= addr[31:5];
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= nxt_ptr;
      end
   end

   // Queue payload: every countdown ticks toward 0; a push reloads its slot.
   always_ff @(posedge clk) begin
      for (int i = 0; i < QUEUE_DEPTH; i++) begin
         if (q_cd[i] != '0) q_cd[i] <= q_cd[i] - CD_ONE;
      end
      if (push) begin
         q_cd[wr_ptr]   <= CD_LOAD;
         q_line[wr_ptr] <= addr[31:5];
      end
   end

   // Line array; contents survive reset.
   always_ff @(posedge clk) begin
      if (mem_we && !rst) mem[wr_idx] <= wdata;
   end

   assign rvalid = (ret_state == RET_BEAT);
   assign raddr  = rvalid ? {q_line[rd_ptr], 5'd0} : 32'd0;
   assign rdata  = rvalid ? mem[{q_line[rd_ptr][LINE_BITS-1:0], beat}] : 64'd0;
   assign ready  = ready_q;
   assign err    = err_q;

endmodule
